// File: rtl/pipe_stage_chain.sv
// Stall/flush-aware register chain: STAGES x {valid, WIDTH data}, registered occupancy.
// Define PIPE_STALL_COUNT_EN to add the saturating 16-bit stall_count output.
module pipe_stage_chain #(
  parameter  int WIDTH     = 32,
  parameter  int STAGES    = 4,
  parameter  int STALL_POS = 1,
  parameter  int FLUSH_POS = 1,
  localparam int OCC_W     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STALL_COUNT_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d, prev_d;
  logic [STAGES-1:0]            vld_pipe, vld_d, prev_v;

  // Upstream view of every stage: stage 0 sees the input port.
  assign prev_d = {data_q[STAGES-2:0], in_data};
  assign prev_v = {vld_pipe[STAGES-2:0], in_valid};

  function automatic logic [OCC_W-1:0] popcnt(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) c = c + OCC_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    data_d = data_q;
    vld_d  = vld_pipe;
    if (ena) begin
      for (int i = 0; i < STAGES; i++) begin
        data_d[i] = prev_d[i];
        vld_d[i]  = prev_v[i];
        if (stall && i < STALL_POS) begin
          data_d[i] = data_q[i];
          vld_d[i]  = vld_pipe[i];
        end
        // Bubble is forced even if the upstream stage is already empty.
        if (stall && i == STALL_POS) begin
          data_d[i] = '0;
          vld_d[i]  = 1'b0;
        end
        if (flush && i < FLUSH_POS) begin
          data_d[i] = '0;
          vld_d[i]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      vld_pipe  <= '0;
      occupancy <= '0;
    end else if (ena) begin
      data_q    <= data_d;
      vld_pipe  <= vld_d;
      occupancy <= popcnt(vld_d);
    end
  end

`ifdef PIPE_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                      stall_count <= '0;
    else if (ena && stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif

  assign out_data  = data_q[STAGES-1];
  assign out_valid = vld_pipe[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (WIDTH=32, STAGES=4, STALL_POS=1, FLUSH_POS=1).
module tb_pipe_stage_chain;
  logic        clk = 1'b0;
  logic        rst, ena, in_valid, stall, flush;
  logic [31:0] in_data, out_data;
  logic        out_valid;
  logic [2:0]  occupancy;
  logic [15:0] stall_count;
  logic        ena_q = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(32), .STAGES(4), .STALL_POS(1), .FLUSH_POS(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .occupancy(occupancy)
`ifdef PIPE_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

`ifndef PIPE_STALL_COUNT_EN
  assign stall_count = '0;
`endif

  // Only edges that actually advanced the pipe present a new output.
  always @(posedge clk) ena_q <= ena;

  always @(negedge clk) begin
    if (ena_q && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%h expected=none", out_data);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data got=%h expected=%h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic f);
    in_valid = v; in_data = d; stall = s; flush = f;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
`ifdef PIPE_STALL_COUNT_EN
    chk("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    rst = 1'b0; ena = 1'b1;

    // Stream A0..A5, then invalid filler with nonzero data
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'hA0 + k, 1'b0, 1'b0);
      sb.push_back(32'hA0 + k);
      step();
      if (k == 2) chk("lat_not_yet", 32'(out_valid), 32'd0);
      if (k == 3) chk("stream_occ_full", 32'(occupancy), 32'd4);
    end
    drive(1'b0, 32'h5A, 1'b0, 1'b0);
    repeat (4) step();
    chk("invalid_data_passes", out_data, 32'h5A);
    chk("invalid_valid", 32'(out_valid), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);

    // Two-cycle stall with B2 in stage 0
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hB0 + k, 1'b0, 1'b0);
      sb.push_back(32'hB0 + k);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step(); step();
    drive(1'b1, 32'hB3, 1'b0, 1'b0);
    sb.push_back(32'hB3);
    step();
    chk("stall_bubble1", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("stall_bubble2", 32'(out_valid), 32'd0);
    step();
    chk("stall_b2_valid", 32'(out_valid), 32'd1);
    chk("stall_b2_data", out_data, 32'hB2);
    repeat (3) step();
`ifdef PIPE_STALL_COUNT_EN
    chk("stall_count_2", 32'(stall_count), 32'd2);
`endif

    // Stall+flush with C0 in stage 0; C0 must vanish
    drive(1'b1, 32'hC1, 1'b0, 1'b0); sb.push_back(32'hC1); step();
    drive(1'b1, 32'hC2, 1'b0, 1'b0); sb.push_back(32'hC2); step();
    drive(1'b1, 32'hC0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hDD, 1'b1, 1'b1); step();
    chk("sf_occ", 32'(occupancy), 32'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) step();
    chk("sf_drained_valid", 32'(out_valid), 32'd0);
    chk("sf_drained_occ", 32'(occupancy), 32'd0);

    // Freeze a full pipe with stall and flush asserted
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hE0 + k, 1'b0, 1'b0);
      sb.push_back(32'hE0 + k);
      step();
    end
    chk("fill_occ", 32'(occupancy), 32'd4);
    ena = 1'b0;
    drive(1'b1, 32'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_valid", 32'(out_valid), 32'd1);
      chk("frz_data", out_data, 32'hE0);
      chk("frz_occ", 32'(occupancy), 32'd4);
`ifdef PIPE_STALL_COUNT_EN
      chk("frz_stall_count", 32'(stall_count), 32'd3);
`endif
    end

    // Reset over a full pipe discards E1..E3
    rst = 1'b1; ena = 1'b1;
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    step();
    sb.delete();
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_data", out_data, 32'd0);
    chk("rst2_occ", 32'(occupancy), 32'd0);
`ifdef PIPE_STALL_COUNT_EN
    chk("rst2_stall_count", 32'(stall_count), 32'd0);
`endif
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef PIPE_STALL_COUNT_EN
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (65534) step();
    chk("sat_preload", 32'(stall_count), 32'hFFFE);
    step();
    chk("sat_reach", 32'(stall_count), 32'hFFFF);
    step(); step();
    chk("sat_hold", 32'(stall_count), 32'hFFFF);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
`endif

    repeat (5) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width of each stage register in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, number of chained stage registers; legal range 2..16.
REQ-003 The block SHALL have parameter STALL_POS, default 1, index of the first stage that receives a bubble on stall; legal range 1..STAGES-1.
REQ-004 The block SHALL have parameter FLUSH_POS, default 1, number of leading stages cleared on flush; legal range 1..STAGES.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high, with ports clk and rst.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ena  in  1  global advance enable; 0 freezes all state
- in_data  in  WIDTH  payload into stage 0
- in_valid  in  1  payload qualifier
- stall  in  1  hazard stop: hold stages 0..STALL_POS-1, bubble into STALL_POS
- flush  in  1  branch kill: clear stages 0..FLUSH_POS-1
- out_data  out  WIDTH  payload of stage STAGES-1
- out_valid  out  1  valid of stage STAGES-1
- occupancy  out  clog2(STAGES+1)  count of valid stages
- stall_count  out  16  stall-cycle counter (only with PIPE_STALL_COUNT_EN)

Function
REQ-007 Stage i SHALL consist of a WIDTH-bit data register and a 1-bit valid register, i = 0..STAGES-1.
REQ-008 Normal cycle (ena=1, stall=0, flush=0): stage 0 SHALL load {in_valid, in_data}; stage i>0 SHALL load stage i-1.
REQ-009 Latency SHALL be exactly STAGES clock edges from in_data sampled to out_data/out_valid, with no stalls or flushes.
REQ-010 When ena=0, every stage register and occupancy SHALL hold, regardless of stall and flush; stall_count SHALL hold.
REQ-011 When ena=1 and stall=1: stages 0..STALL_POS-1 SHALL hold; stage STALL_POS SHALL load valid=0, data=0; stages above STALL_POS SHALL advance.
REQ-012 When ena=1 and flush=1: stages 0..FLUSH_POS-1 SHALL load valid=0, data=0; flush SHALL override hold and advance for those stages.
REQ-013 When stall and flush are both asserted, REQ-012 SHALL apply to stages below FLUSH_POS, and REQ-011 SHALL apply to all other stages.
REQ-014 A stall SHALL still insert the bubble when stage STALL_POS-1 is already invalid; no payload SHALL be duplicated or lost across a stall.
REQ-015 Invalid stages SHALL carry data=0 whenever the bubble comes from stall, flush or reset; in_data with in_valid=0 SHALL propagate unchanged.
REQ-016 occupancy SHALL be a registered count equal to the number of stage valid bits set after each edge.
REQ-017 out_data and out_valid SHALL be driven directly from stage STAGES-1 registers, with no combinational path from any input.

Reset
REQ-018 With rst=1 at a rising edge: all valid bits SHALL be 0, all data SHALL be 0, occupancy SHALL be 0, and stall_count SHALL be 0.
REQ-019 rst SHALL have priority over ena, stall and flush; reset mid-stream SHALL discard all in-flight payloads.

Configuration
REQ-020 With macro PIPE_STALL_COUNT_EN defined, stall_count SHALL increment by 1 on each edge with ena=1 and stall=1, SHALL saturate at 16'hFFFF, and SHALL clear on rst.
REQ-021 Without PIPE_STALL_COUNT_EN, port stall_count and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification (WIDTH=32, STAGES=4, STALL_POS=1, FLUSH_POS=1, macro defined)
REQ-022 Reset: rst=1 for 1 edge with pipe full -> out_valid=0, out_data=0, occupancy=0, stall_count=0.
REQ-023 Stream: 0xA0..0xA5 valid, one per cycle -> 0xA0 appears at out after 4 edges, then 0xA1..0xA5 consecutive; occupancy reaches 4.
REQ-024 Stall: stall=1 for 2 cycles while 0xB2 is in stage 0 -> two invalid out cycles, then 0xB2 once, order intact; stall_count=2.
REQ-025 Stall+flush: both asserted one cycle with 0xC0 in stage 0 -> 0xC0 never reaches out, stage 1 bubble, stages 2..3 advance.
REQ-026 Freeze: ena=0 for 3 cycles with stall=1 and flush=1 -> all outputs, occupancy and stall_count unchanged.
REQ-027 Saturation: stall_count preloaded to 16'hFFFE via 65534 stall cycles, then 3 more -> stall_count=16'hFFFF.
